acc_state_capture: RTL

- Sits directly downstream of the per-element mix/accumulate stage.
- Detects the end of each readout window, which is the falling edge of the accumulator valid, and captures the final accx/accy.
- Projects the captured IQ pair onto a programmable rotation axis and thresholds the result to a 1-bit qubit state.
- Pushes {tag, state, accx, accy} into a result FIFO. The processor or a DMA drains it through a valid/ready interface.

---
 rtl/acc_state_pkg.sv | 21 ++
 rtl/acc_state_capture_if.sv | 12 +
 rtl/result_fifo.sv | 54 +++++
 rtl/acc_state_capture.sv | 108 ++++++++++
 4 files changed

// File: rtl/acc_state_pkg.sv
// Shared types and helpers for the readout state-capture block.
// Result layout, fixed-point scale and projection width.
package acc_state_pkg;

    localparam int ACC_W  = 32;
    localparam int TAG_W  = 8;
    localparam int Q_FRAC = 15;

    typedef struct packed {
        logic [TAG_W-1:0]        tag;
        logic                    state;
        logic signed [ACC_W-1:0] accx;
        logic signed [ACC_W-1:0] accy;
    } result_t;

    // Width of (accx*cos + accy*sin) >>> Q_FRAC with no saturation.
    function automatic int proj_width(input int acc_w);
        return acc_w + 2;
    endfunction

endpackage

// File: rtl/acc_state_capture_if.sv
// Result read port: FWFT valid/ready handshake.
// master = producer (FIFO side), slave = consumer.
interface acc_state_capture_if #(
    parameter int W = $bits(acc_state_pkg::result_t)
);
    logic         rd_valid;
    logic         rd_ready;
    logic [W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module result_fifo #(
    parameter int W     = 73,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop_req,
    output logic                     accept,
    output logic                     valid,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop;

    assign full   = (count == CW'(DEPTH));
    assign valid  = (count != '0);
    assign pop    = valid & pop_req;
    assign accept = push & (~full | pop);
    assign dout   = valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            unique case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since valid gates dout.
    always_ff @(posedge clk) begin
        if (!reset && accept) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/acc_state_capture.sv
// Captures final accx/accy on the falling edge of acc_valid, projects onto
// the rotation axis, thresholds to a qubit state and queues the result.
module acc_state_capture
    import acc_state_pkg::*;
#(
    parameter int ACCWIDTH   = 32,
    parameter int TAGWIDTH   = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        acc_valid,
    input  logic signed [ACCWIDTH-1:0]  accx,
    input  logic signed [ACCWIDTH-1:0]  accy,
    input  logic signed [15:0]          rotcos,
    input  logic signed [15:0]          rotsin,
    input  logic signed [ACCWIDTH-1:0]  thresh,
    input  logic                        ovf_clr,
    acc_state_capture_if.master         rd,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow
);
    localparam int PW = proj_width(ACCWIDTH);
    localparam int MW = ACCWIDTH + 16;
    localparam int SW = MW + 1;
    localparam int DW = TAGWIDTH + 1 + 2 * ACCWIDTH;

    logic                       acc_valid_d;
    logic                       fall;
    logic [TAGWIDTH-1:0]        tag;

    logic                       s0_v, s1_v, s2_v;
    logic [TAGWIDTH-1:0]        s0_tag, s1_tag, s2_tag;
    logic signed [ACCWIDTH-1:0] s0_x, s0_y, s1_x, s1_y, s2_x, s2_y;
    logic signed [MW-1:0]       s1_px, s1_py;
    logic                       s2_state;

    logic signed [SW-1:0]       sum;
    logic signed [PW-1:0]       proj;
    logic signed [PW-1:0]       thr_ext;
    logic                       accept;

    assign fall    = acc_valid_d & ~acc_valid;
    assign sum     = {s1_px[MW-1], s1_px} + {s1_py[MW-1], s1_py};
    assign proj    = sum[SW-1:Q_FRAC];
    assign thr_ext = {{(PW-ACCWIDTH){thresh[ACCWIDTH-1]}}, thresh};

    // Window-end detection and shot tag counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_valid_d <= 1'b0;
            tag         <= '0;
        end else begin
            acc_valid_d <= acc_valid;
            if (fall) tag <= tag + TAGWIDTH'(1);
        end
    end

    // S0 capture, S1 products, S2 projection and threshold.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_v <= 1'b0;
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s0_v <= fall;
            s1_v <= s0_v;
            s2_v <= s1_v;
        end
        if (fall) begin
            s0_tag <= tag;
            s0_x   <= accx;
            s0_y   <= accy;
        end
        s1_tag   <= s0_tag;
        s1_x     <= s0_x;
        s1_y     <= s0_y;
        s1_px    <= MW'(s0_x) * MW'(rotcos);
        s1_py    <= MW'(s0_y) * MW'(rotsin);
        s2_tag   <= s1_tag;
        s2_x     <= s1_x;
        s2_y     <= s1_y;
        s2_state <= (proj > thr_ext);
    end

    // Sticky drop flag; a new drop wins over a clear.
    always_ff @(posedge clk) begin
        if (reset)              overflow <= 1'b0;
        else if (s2_v & ~accept) overflow <= 1'b1;
        else if (ovf_clr)       overflow <= 1'b0;
    end

    result_fifo #(
        .W     (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (s2_v),
        .din     ({s2_tag, s2_state, s2_x, s2_y}),
        .pop_req (rd.rd_ready),
        .accept  (accept),
        .valid   (rd.rd_valid),
        .dout    (rd.rd_data),
        .count   (count)
    );

endmodule
